regfile: RTL

Architectural register file at the write-back end of the pipeline. It accepts the write-back triple (data, enable, address) from the MEM/WB stage register and serves two combinational read ports to the decode stage. Same-cycle write-to-read bypass removes the WB→ID hazard. It holds the eight general registers R0–R7 and the special registers SP, IH, RA and T. T is also exported directly for conditional-branch evaluation.

---
 rtl/regfile.sv | 85 ++++++++
 1 files changed

// File: rtl/regfile.sv
// regfile: architectural register file (R0-R7, SP, IH, RA, T) at the
// write-back end of the pipeline. It has one write port and two
// combinational read ports. A write presented in the same cycle is
// bypassed to the read ports. T is also exported directly for branch
// evaluation.
module regfile #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wReg_i,
    input  logic [ADDR_W-1:0] wRegAddr_i,
    input  logic [DATA_W-1:0] wData_i,
    input  logic              rReg1_i,
    input  logic [ADDR_W-1:0] rRegAddr1_i,
    output logic [DATA_W-1:0] rData1_o,
    input  logic              rReg2_i,
    input  logic [ADDR_W-1:0] rRegAddr2_i,
    output logic [DATA_W-1:0] rData2_o,
    output logic [DATA_W-1:0] t_o
);

    // Only addresses 0..11 have storage. 12..14 are reserved and 15 is the
    // null register, so both of those groups read as zero.
    localparam int NUM_REGS = 12;
    localparam int T_IDX    = 11;

    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic [DATA_W-1:0] regs_d [NUM_REGS];

    // One independent register per storage slot. An exact full-width address
    // match is required, so writes to 12..15 never reach any slot.
    generate
        for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
            // Next-state: clear on reset, load on an addressed write, else hold.
            always_comb begin
                regs_d[gi] = regs_q[gi];
                if (rst) begin
                    regs_d[gi] = '0;
                end else if (wReg_i && (wRegAddr_i == ADDR_W'(gi))) begin
                    regs_d[gi] = wData_i;
                end
            end

            // State register for slot gi.
            always_ff @(posedge clk) begin
                regs_q[gi] <= regs_d[gi];
            end
        end
    endgenerate

    // Shared read-path priority: reset, enable, address range, bypass, storage.
    function automatic logic [DATA_W-1:0] read_port(
        input logic              en,
        input logic [ADDR_W-1:0] addr
    );
        logic [DATA_W-1:0] val;
        val = '0;
        if (rst || !en) begin
            val = '0;
        end else if (addr >= ADDR_W'(NUM_REGS)) begin
            val = '0;
        end else if (wReg_i && (wRegAddr_i == addr)) begin
            val = wData_i;
        end else begin
            val = regs_q[addr];
        end
        return val;
    endfunction

    // Read port 1: combinational with same-cycle write bypass.
    always_comb begin
        rData1_o = read_port(rReg1_i, rRegAddr1_i);
    end

    // Read port 2: independent of port 1, and it can bypass in the same cycle.
    always_comb begin
        rData2_o = read_port(rReg2_i, rRegAddr2_i);
    end

    // T comes straight from storage. The branch unit does its own forwarding.
    assign t_o = regs_q[T_IDX];

endmodule
